// File: rtl/aq_djpeg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aq_djpeg_pkg
//  Purpose  : Shared types and constants for the djpeg zigzag read path.
//             Holds the reader state encoding, the zigzag buffer geometry,
//             the per-beat sideband tag and a helper that maps the
//             blocks-per-MCU configuration to an effective block count.
//  Revision : 1.0 - initial release
// ============================================================================
package aq_djpeg_pkg;

    // One 8x8 block is read as 32 words of two coefficients each.
    localparam int ZZ_WORDS  = 32;
    localparam int ZZ_ADDR_W = 5;
    localparam int COLOR_W   = 3;
    localparam int BLK_CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_GAP  = 2'd2
    } zz_state_t;

    // Sideband that travels with every coefficient pair.
    typedef struct packed {
        logic [ZZ_ADDR_W-1:0] index;
        logic [COLOR_W-1:0]   color;
        logic                 block_last;
        logic                 mcu_last;
    } beat_tag_t;

    localparam int TAG_W = $bits(beat_tag_t);

    // A configured count of zero behaves as a single block per MCU.
    function automatic logic [BLK_CNT_W-1:0] eff_blocks(input logic [BLK_CNT_W-1:0] cfg);
        return (cfg == '0) ? BLK_CNT_W'(1) : cfg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aq_djpeg_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : aq_djpeg_skid_fifo
//  Purpose  : Small synchronous FIFO used as the output skid buffer of the
//             zigzag reader. Push and pop may happen in the same cycle; a
//             push into a full FIFO without a simultaneous pop is illegal.
//  Ports    : clk, rst (sync, active-low), flush (sync clear),
//             push/push_data, pop, head_data (entry at the read pointer),
//             count, empty, full.
//  Revision : 1.0 - initial release
// ============================================================================
module aq_djpeg_skid_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign do_pop    = pop & ~empty;
    // When full, the slot being popped is the one written, so push+pop is safe.
    assign do_push   = push & (~full | do_pop);
    assign head_data = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage carries no reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush) begin
            assert (!(push && full && !pop));
        end
    end

endmodule
`default_nettype wire

// File: rtl/aq_djpeg_zz_reader.sv
`default_nettype none
// ============================================================================
//  Module   : aq_djpeg_zz_reader
//  Purpose  : Reads complete 8x8 blocks (32 two-coefficient words) out of the
//             zigzag buffer and streams them to the IDCT with per-beat
//             sideband (index, color, block_last, mcu_last). Reads are only
//             issued while the output skid FIFO plus the in-flight word can
//             still absorb them, so backpressure never loses a beat.
//  Ports    : clk, rst (sync, active-low), data_init (soft clear),
//             cfg_blocks_per_mcu,
//             zz_enable/zz_color/zz_data_a/zz_data_b  - buffer side inputs
//             zz_read/zz_address                      - buffer read request
//             out_valid/out_ready/out_data_a/out_data_b/out_index/
//             out_color/out_block_last/out_mcu_last   - IDCT stream
//             busy                                    - activity flag
//  Revision : 1.0 - initial release
// ============================================================================
module aq_djpeg_zz_reader
    import aq_djpeg_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_init,
    input  logic [3:0]           cfg_blocks_per_mcu,
    input  logic                 zz_enable,
    input  logic [2:0]           zz_color,
    input  logic [DATA_W-1:0]    zz_data_a,
    input  logic [DATA_W-1:0]    zz_data_b,
    output logic                 zz_read,
    output logic [4:0]           zz_address,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data_a,
    output logic [DATA_W-1:0]    out_data_b,
    output logic [4:0]           out_index,
    output logic [2:0]           out_color,
    output logic                 out_block_last,
    output logic                 out_mcu_last,
    output logic                 busy
);

    localparam int FIFO_W = 2 * DATA_W + TAG_W;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    zz_state_t              state;
    zz_state_t              state_next;
    logic                   issue;
    logic                   issue_ok;
    logic [ZZ_ADDR_W-1:0]   addr_cnt;
    logic [BLK_CNT_W-1:0]   blk_cnt;
    logic [BLK_CNT_W-1:0]   n_blocks;
    logic [COLOR_W-1:0]     color_reg;
    logic [COLOR_W-1:0]     color_now;
    logic                   last_addr;
    logic                   last_blk;
    logic                   inflight;
    beat_tag_t              tag_d;
    beat_tag_t              tag_q;

    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [FIFO_W-1:0]      fifo_head;
    logic                   pop;
    logic [CNT_W:0]         pending;

    logic [DATA_W-1:0]      head_a;
    logic [DATA_W-1:0]      head_b;
    beat_tag_t              head_tag;

    assign last_addr = (addr_cnt == ZZ_ADDR_W'(ZZ_WORDS - 1));
    assign last_blk  = (blk_cnt >= n_blocks - BLK_CNT_W'(1));

    // Occupancy the FIFO will have once the in-flight word lands and this
    // cycle's pop retires; a new read is allowed only if it still fits.
    assign pop      = out_valid & out_ready;
    assign pending  = {1'b0, fifo_count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    assign issue_ok = (pending < (CNT_W+1)'(FIFO_DEPTH));

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            S_IDLE: begin
                if (zz_enable && !data_init) begin
                    state_next = S_READ;
                end
            end
            S_READ: begin
                // zz_enable is not looked at here: a started block always completes.
                issue = issue_ok && !data_init && rst;
                if (issue && last_addr) begin
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                // One idle cycle lets the buffer retire the bank just read
                // before zz_enable is trusted again.
                state_next = zz_enable ? S_READ : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (data_init) begin
            state_next = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Address, block and color bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst || data_init) begin
            addr_cnt <= '0;
            blk_cnt  <= '0;
        end else begin
            if (state != S_READ) begin
                addr_cnt <= '0;
            end else if (issue) begin
                addr_cnt <= addr_cnt + ZZ_ADDR_W'(1);
            end
            if (issue && last_addr) begin
                blk_cnt <= last_blk ? '0 : blk_cnt + BLK_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            n_blocks  <= BLK_CNT_W'(1);
            color_reg <= '0;
        end else begin
            if (state == S_IDLE) begin
                n_blocks <= eff_blocks(cfg_blocks_per_mcu);
            end
            if (issue && (addr_cnt == '0)) begin
                color_reg <= zz_color;
            end
        end
    end

    // Word 0 takes the color straight from the buffer; the rest of the
    // block uses the value latched when word 0 was read.
    assign color_now = (addr_cnt == '0) ? zz_color : color_reg;

    always_comb begin
        tag_d            = '0;
        tag_d.index      = addr_cnt;
        tag_d.color      = color_now;
        tag_d.block_last = last_addr;
        tag_d.mcu_last   = last_addr & last_blk;
    end

    // ------------------------------------------------------------------
    // Tag pipeline: aligns the sideband with the buffer's 1-cycle read data
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst || data_init) begin
            inflight <= 1'b0;
            tag_q    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                tag_q <= tag_d;
            end
        end
    end

    aq_djpeg_skid_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (data_init),
        .push      (inflight),
        .push_data ({zz_data_a, zz_data_b, tag_q}),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign {head_a, head_b, head_tag} = fifo_head;

    // ------------------------------------------------------------------
    // Outputs: head of FIFO, forced to zero while empty so stale RAM
    // contents never appear on the stream
    // ------------------------------------------------------------------
    assign out_valid      = ~fifo_empty;
    assign out_data_a     = out_valid ? head_a : '0;
    assign out_data_b     = out_valid ? head_b : '0;
    assign out_index      = out_valid ? head_tag.index : '0;
    assign out_color      = out_valid ? head_tag.color : '0;
    assign out_block_last = out_valid & head_tag.block_last;
    assign out_mcu_last   = out_valid & head_tag.mcu_last;

    assign zz_read    = issue;
    assign zz_address = addr_cnt;
    assign busy       = (state != S_IDLE) | ~fifo_empty;

    // fifo_full is only needed inside the FIFO's own overflow check.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule
`default_nettype wire

// File: tb/tb_aq_djpeg_zz_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aq_djpeg_zz_reader
//  Purpose  : Self-checking bench for aq_djpeg_zz_reader. A behavioural
//             zigzag buffer returns a = address, b = address + 32 and a
//             color equal to the bank number; a scoreboard predicts every
//             beat from the bench's own block bookkeeping.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aq_djpeg_zz_reader;
    import aq_djpeg_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_init;
    logic [3:0]  cfg_blocks_per_mcu;
    logic        zz_enable;
    logic [2:0]  zz_color;
    logic [15:0] zz_data_a;
    logic [15:0] zz_data_b;
    logic        zz_read;
    logic [4:0]  zz_address;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data_a;
    logic [15:0] out_data_b;
    logic [4:0]  out_index;
    logic [2:0]  out_color;
    logic        out_block_last;
    logic        out_mcu_last;
    logic        busy;

    aq_djpeg_zz_reader #(.DATA_W(16), .FIFO_DEPTH(2)) dut (
        .clk                (clk),
        .rst                (rst),
        .data_init          (data_init),
        .cfg_blocks_per_mcu (cfg_blocks_per_mcu),
        .zz_enable          (zz_enable),
        .zz_color           (zz_color),
        .zz_data_a          (zz_data_a),
        .zz_data_b          (zz_data_b),
        .zz_read            (zz_read),
        .zz_address         (zz_address),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data_a         (out_data_a),
        .out_data_b         (out_data_b),
        .out_index          (out_index),
        .out_color          (out_color),
        .out_block_last     (out_block_last),
        .out_mcu_last       (out_mcu_last),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // ---------------- zigzag buffer model ----------------
    int   loaded   = 0;   // blocks written into the buffer by the bench
    int   consumed = 0;   // banks retired by a read of address 31
    logic en_mask  = 1'b0;
    int   cyc      = 0;

    assign zz_enable = (loaded > consumed) && !en_mask;
    assign zz_color  = 3'(consumed);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (zz_read) begin
            zz_data_a <= 16'(zz_address);
            zz_data_b <= 16'(zz_address) + 16'd32;
            if (zz_address == 5'd31) consumed <= consumed + 1;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    int exp_idx, exp_blk, exp_bank, sb_n;
    int beats, mcus, reads, reads31;
    int first_read, last_read, first_valid, last_valid;

    task automatic reset_sb(input int n);
        exp_idx  = 0;
        exp_blk  = 0;
        exp_bank = consumed;
        sb_n     = n;
    endtask

    task automatic clear_stats();
        beats = 0; mcus = 0; reads = 0; reads31 = 0;
        first_read = -1; last_read = -1; first_valid = -1; last_valid = -1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (zz_read) begin
                reads++;
                if (first_read < 0) first_read = cyc;
                last_read = cyc;
                if (zz_address == 5'd31) reads31++;
            end
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                last_valid = cyc;
                // checked every valid cycle, so a stall that changes the head is caught
                check("index", 64'(out_index), 64'(exp_idx));
                check("data_a", 64'(out_data_a), 64'(exp_idx));
                check("data_b", 64'(out_data_b), 64'(exp_idx + 32));
                check("color", 64'(out_color), 64'(exp_bank % 8));
                check("block_last", 64'(out_block_last), 64'(exp_idx == 31));
                check("mcu_last", 64'(out_mcu_last), 64'((exp_idx == 31) && (exp_blk == sb_n - 1)));
                if (out_ready) begin
                    beats++;
                    if (out_mcu_last) mcus++;
                    if (exp_idx == 31) begin
                        exp_idx  = 0;
                        exp_bank = exp_bank + 1;
                        exp_blk  = (exp_blk == sb_n - 1) ? 0 : exp_blk + 1;
                    end else begin
                        exp_idx = exp_idx + 1;
                    end
                end
            end
        end
    end

    task automatic wait_beats(input int target, input int budget, input string tag);
        int n = 0;
        while (beats < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (beats < target) check({tag, "_timeout"}, 64'(beats), 64'(target));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic start_test(input logic [3:0] cfg, input int blocks);
        int n;
        cfg_blocks_per_mcu = cfg;
        n = (cfg == 0) ? 1 : int'(cfg);
        reset_sb(n);
        clear_stats();
        @(posedge clk); #1;
        loaded = loaded + blocks;
    endtask

    initial begin
        rst = 1'b0; data_init = 1'b0; out_ready = 1'b1; cfg_blocks_per_mcu = 4'd1;
        zz_data_a = '0; zz_data_b = '0;
        reset_sb(1); clear_stats();

        // ---- reset values ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {zz_read, zz_address, out_valid, out_data_a, out_data_b, out_index,
                              out_color, out_block_last, out_mcu_last, busy}, 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_valid", 64'(out_valid), 64'd0);

        // ---- single block ----
        start_test(4'd1, 1);
        wait_beats(32, 200, "single");
        wait_idle(50);
        check("single_latency", 64'(first_valid - first_read), 64'd2);
        check("single_beats", 64'(beats), 64'd32);
        check("single_contig", 64'(last_valid - first_valid + 1), 64'd32);
        check("single_reads", 64'(reads), 64'd32);
        check("single_read31", 64'(reads31), 64'd1);
        check("single_mcu", 64'(mcus), 64'd1);

        // ---- back-to-back, cfg = 3 ----
        start_test(4'd3, 3);
        wait_beats(96, 400, "b2b");
        wait_idle(50);
        check("b2b_beats", 64'(beats), 64'd96);
        check("b2b_read_span", 64'(last_read - first_read + 1), 64'd98);
        check("b2b_mcu", 64'(mcus), 64'd1);
        check("b2b_read31", 64'(reads31), 64'd3);

        // ---- backpressure on cycles 5..14 ----
        start_test(4'd1, 1);
        for (int c = 0; c < 20; c++) begin
            out_ready = !(c >= 5 && c <= 14);
            if (c == 14) begin
                @(negedge clk);
                check("bp_no_read", 64'(zz_read), 64'd0);
                check("bp_fifo_full", 64'(dut.fifo_count), 64'd2);
                check("bp_valid", 64'(out_valid), 64'd1);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_beats(32, 200, "bp");
        wait_idle(50);
        check("bp_beats", 64'(beats), 64'd32);
        check("bp_reads", 64'(reads), 64'd32);

        // ---- random ready, 8 blocks, cfg = 4 ----
        start_test(4'd4, 8);
        for (int c = 0; c < 4000 && beats < 256; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_beats(256, 200, "rand");
        wait_idle(50);
        check("rand_beats", 64'(beats), 64'd256);
        check("rand_mcu", 64'(mcus), 64'd2);

        // ---- data_init at index 17 ----
        start_test(4'd2, 2);
        begin
            int n = 0;
            @(negedge clk);
            while (!(out_valid && out_index == 5'd17) && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("di_found17", 64'(out_index), 64'd17);
        end
        data_init = 1'b1;
        @(posedge clk); #1;
        data_init = 1'b0;
        reset_sb(2); clear_stats();
        @(negedge clk);
        check("di_state", 64'(dut.state), 64'(S_IDLE));
        check("di_valid", 64'(out_valid), 64'd0);
        check("di_read", 64'(zz_read), 64'd0);
        check("di_blk", 64'(dut.blk_cnt), 64'd0);
        wait_beats(64, 400, "di");
        wait_idle(50);
        check("di_beats", 64'(beats), 64'd64);
        check("di_mcu", 64'(mcus), 64'd1);

        // ---- reset mid-stream ----
        start_test(4'd1, 2);
        wait_beats(10, 200, "rst_pre");
        rst = 1'b0;
        en_mask = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_rst_outputs", {zz_read, zz_address, out_valid, out_data_a, out_data_b, out_index,
                                  out_color, out_block_last, out_mcu_last, busy}, 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("mid_rst_noread", 64'(zz_read), 64'd0);
            check("mid_rst_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        reset_sb(1); clear_stats();
        en_mask = 1'b0;
        wait_beats(64, 400, "rst_post");
        wait_idle(50);
        check("rst_post_beats", 64'(beats), 64'd64);
        check("rst_post_mcu", 64'(mcus), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
